rv32i_wb_trace_buffer: RTL and testbench
========================================

# rv32i_wb_trace_buffer

Commit-trace capture stage placed directly downstream of `iiitb_rv32i`. It watches the core's `NPC` and `WB_OUT` outputs and detects each instruction retirement as a change in `NPC`. Every retirement is stored as a timestamped record in a show-ahead FIFO. A valid/ready port drains the records to a logger or debug link, and overflow is accounted for rather than silently lost.

## Interface
- `DEPTH`, default 16: FIFO entries. Must be a power of two, ≥ 2.
- `TS_W`, default 16: timestamp width.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `RN`  in  1: reset, synchronous and active-high.
- `NPC`  in  32: next-PC from core.
- `WB_OUT`  in  32: writeback value from core.
- `en`  in  1: capture enable.
- `out_ready`  in  1: consumer accepts head record.
- `clr_ovf`  in  1: clears `overflow` and `drop_cnt`.
- `out_valid`  out  1: head record present (FIFO not empty).
- `out_pc`  out  32: head record NPC.
- `out_wb`  out  32: head record WB_OUT.
- `out_ts`  out  TS_W: head record timestamp.
- `level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky flag, set when a record was dropped.
- `drop_cnt`  out  16: dropped-record count, saturating.

## Operation
**Timestamp**
- `ts` is a free-running TS_W counter. It increments every cycle and wraps from all-ones to 0.

**Capture FSM**
- States: `UNARMED` and `ARMED`.
- `prev_npc` loads `NPC` every non-reset cycle, regardless of `en` or state.
- `UNARMED` → `ARMED` on the first non-reset edge. No event is produced on that edge.
- `ARMED` remains `ARMED` until reset.
- **Event:** produced when `ARMED && en && (NPC != prev_npc)`.
- **Record contents:** {`NPC`, `WB_OUT`, `ts`} as sampled at the event edge.

**FIFO**
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` tracks occupancy.
- **Pop:** occurs when `out_valid && out_ready`.
- **Push:** occurs on an event when `level < DEPTH`, or when `level == DEPTH` and a pop happens in the same cycle. In that case `level` stays at DEPTH.
- **Drop:** an event with `level == DEPTH` and no pop.
  - The record is discarded.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 16'hFFFF.
- **Empty with event:** push only, with no bypass. `out_valid` stays 0 in that cycle.
- **`clr_ovf`:** `overflow` ← 0 and `drop_cnt` ← 0. If a drop occurs in the same cycle, the drop wins: `overflow` = 1, `drop_cnt` = 1.
- **Outputs when empty:** `out_pc`, `out_wb` and `out_ts` read combinationally from the head entry and are forced to 0 when `out_valid` = 0.

## Timing
- **Reset values (`RN` = 1 at an edge):**
  - state = `UNARMED`, `ts` = 0, `prev_npc` = 0.
  - Pointers = 0, `level` = 0, `out_valid` = 0.
  - `out_pc`, `out_wb`, `out_ts` = 0.
  - `overflow` = 0, `drop_cnt` = 0.
- **Reset mid-operation:** flushes all contents with no drain and disarms the capture FSM. Events in the reset cycle are ignored.
- **Capture latency:** an event sampled at edge k sets `out_valid` = 1 after edge k. The record is at the head only if the FIFO was empty before edge k.
- **Drain rate:** one record per cycle while `out_ready` = 1.
- **Handshake rules:**
  - `out_valid` does not depend combinationally on `out_ready`.
  - The head record is stable while `out_valid && !out_ready`.
- **Throughput:** one event per cycle is sustained with no loss while `out_ready` = 1 and `level < DEPTH`.

## Test plan
1. **Reset and arming.** Hold `RN` = 1 for 2 cycles with `NPC` = 0x10, then release with `NPC` = 0x10. → On the first free edge: no event, `level` = 0, `out_valid` = 0, all outputs 0.
2. **Single record.** With the block armed and `en` = 1, at ts = 5 change `NPC` from 0x10 to 0x14 with `WB_OUT` = 0xDEADBEEF, `out_ready` = 0. → After that edge: `out_valid` = 1, `out_pc` = 0x14, `out_wb` = 0xDEADBEEF, `out_ts` = 5, `level` = 1.
3. **Fill and drop.** Hold `out_ready` = 0 and produce 18 distinct NPC changes with DEPTH = 16. → `level` = 16, `overflow` = 1, `drop_cnt` = 2. The head is still the first record.
4. **Full with simultaneous pop.** Starting from state 3, set `out_ready` = 1 and raise one event in the same cycle. → `level` stays 16, `drop_cnt` stays 2, and the new record lands at the tail.
5. **Clear versus drop.** With the FIFO full, assert `clr_ovf` alone. → `overflow` = 0, `drop_cnt` = 0. Then assert `clr_ovf` in the same cycle as a drop. → `overflow` = 1, `drop_cnt` = 1.
6. **Enable and wrap.** With `en` = 0, produce 3 NPC changes. → No records. Then push and pop 40 records with `out_ready` = 1. → Order is preserved across pointer wrap, and `out_ts` wraps 0xFFFF → 0 correctly.

Source files
------------

// File: rtl/rv32i_wb_trace_buffer_if.sv
// Valid/ready stream carrying one retirement record (PC, writeback value, timestamp)
// from the trace buffer to a logger or debug link.
interface rv32i_wb_trace_buffer_if #(
   parameter int unsigned TS_W = 16
);
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_pc;
   logic [31:0]     out_wb;
   logic [TS_W-1:0] out_ts;

   modport master (
      output out_valid,
      output out_pc,
      output out_wb,
      output out_ts,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_pc,
      input  out_wb,
      input  out_ts,
      output out_ready
   );
endinterface

// File: rtl/rv32i_wb_trace_buffer.sv
// Commit-trace capture for iiitb_rv32i: a change in NPC marks a retirement, which is
// timestamped and queued in a show-ahead FIFO drained over a valid/ready stream.
module rv32i_wb_trace_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TS_W  = 16
) (
   input  logic                       clk,
   input  logic                       RN,
   input  logic [31:0]                NPC,
   input  logic [31:0]                WB_OUT,
   input  logic                       en,
   input  logic                       clr_ovf,
   rv32i_wb_trace_buffer_if.master    trace,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [15:0]                drop_cnt
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
   localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

   typedef enum logic [0:0] {
      StUnarmed,
      StArmed
   } cap_state_e;

   cap_state_e      state_q;
   logic [31:0]     prev_npc_q;
   logic [TS_W-1:0] ts_q;

   logic [31:0]     pc_mem [DEPTH];
   logic [31:0]     wb_mem [DEPTH];
   logic [TS_W-1:0] ts_mem [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0] level_q, level_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;

   logic ev, full, empty, pop, push, drop;

   // Capture FSM: the first edge after reset only primes prev_npc, so no event fires there.
   always_ff @(posedge clk) begin
      if (RN) begin
         state_q    <= StUnarmed;
         prev_npc_q <= '0;
      end else begin
         prev_npc_q <= NPC;
         case (state_q)
            StUnarmed: state_q <= StArmed;
            StArmed:   state_q <= StArmed;
            default:   state_q <= StUnarmed;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (RN) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   always_comb begin
      ev    = (state_q == StArmed) && en && (NPC != prev_npc_q);
      full  = (level_q == LvlFull);
      empty = (level_q == '0);
      pop   = !empty && trace.out_ready;
      // A full FIFO still accepts a record when the head leaves in the same cycle.
      push  = ev && (!full || pop);
      drop  = ev && full && !pop;
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
      level_d  = level_q + LvlW'(push) - LvlW'(pop);
   end

   // A drop in the same cycle as a clear leaves exactly that one drop recorded.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (clr_ovf) begin
            drop_cnt_d = 16'd1;
         end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (RN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is not reset; empty-state outputs are masked instead.
   always_ff @(posedge clk) begin
      if (!RN && push) begin
         pc_mem[wr_ptr_q] <= NPC;
         wb_mem[wr_ptr_q] <= WB_OUT;
         ts_mem[wr_ptr_q] <= ts_q;
      end
   end

   always_comb begin
      trace.out_valid = !empty;
      trace.out_pc    = empty ? '0 : pc_mem[rd_ptr_q];
      trace.out_wb    = empty ? '0 : wb_mem[rd_ptr_q];
      trace.out_ts    = empty ? '0 : ts_mem[rd_ptr_q];
   end

   assign level    = level_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rv32i_wb_trace_buffer.sv
// Scoreboard bench for rv32i_wb_trace_buffer: directed stimulus pushes expected records,
// a negedge monitor pops and compares every accepted record.
module tb_rv32i_wb_trace_buffer;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] wb;
      logic [15:0] ts;
   } rec_t;

   logic        clk = 1'b0;
   logic        rn;
   logic [31:0] npc;
   logic [31:0] wb_out;
   logic        en;
   logic        clr_ovf;
   logic [4:0]  level;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [15:0] model_ts = '0;

   int checks   = 0;
   int failures = 0;
   rec_t sb[$];

   rv32i_wb_trace_buffer_if #(.TS_W(16)) trace ();

   rv32i_wb_trace_buffer #(
      .DEPTH (16),
      .TS_W  (16)
   ) dut (
      .clk      (clk),
      .RN       (rn),
      .NPC      (npc),
      .WB_OUT   (wb_out),
      .en       (en),
      .clr_ovf  (clr_ovf),
      .trace    (trace),
      .level    (level),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   // Reference timestamp: value the DUT samples at the next rising edge.
   always @(posedge clk) begin
      if (rn) model_ts <= '0;
      else    model_ts <= model_ts + 16'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_rec(input logic [31:0] pc, input logic [31:0] wb);
      rec_t r;
      r.pc = pc;
      r.wb = wb;
      r.ts = model_ts;
      sb.push_back(r);
   endtask

   // Monitor: every accepted head record must match the oldest expected one.
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (!rn && trace.out_valid && trace.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got pc 0x%08h expected no record", trace.out_pc);
            end else begin
               e = sb.pop_front();
               check("sb_pc", trace.out_pc, e.pc);
               check("sb_wb", trace.out_wb, e.wb);
               check("sb_ts", 32'(trace.out_ts), 32'(e.ts));
            end
         end
      end
   end

   initial begin
      int guard;
      rn              = 1'b1;
      npc             = 32'h10;
      wb_out          = '0;
      en              = 1'b1;
      clr_ovf         = 1'b0;
      trace.out_ready = 1'b0;

      // 1. reset and arming
      @(posedge clk);
      @(posedge clk);
      #1;
      rn = 1'b0;
      step();
      check("arm_level", 32'(level), 0);
      check("arm_valid", 32'(trace.out_valid), 0);
      check("arm_pc", trace.out_pc, 0);
      check("arm_wb", trace.out_wb, 0);
      check("arm_ts", 32'(trace.out_ts), 0);
      check("arm_ovf", 32'(overflow), 0);
      check("arm_drop", 32'(drop_cnt), 0);

      // 2. single record at ts = 5
      repeat (4) step();
      npc    = 32'h14;
      wb_out = 32'hDEADBEEF;
      expect_rec(npc, wb_out);
      step();
      check("single_valid", 32'(trace.out_valid), 1);
      check("single_pc", trace.out_pc, 32'h14);
      check("single_wb", trace.out_wb, 32'hDEADBEEF);
      check("single_ts", 32'(trace.out_ts), 5);
      check("single_level", 32'(level), 1);
      trace.out_ready = 1'b1;
      step();
      trace.out_ready = 1'b0;
      check("single_drained", 32'(level), 0);

      // 3. fill and drop
      for (int i = 0; i < 18; i++) begin
         npc    = 32'h100 + 32'(4 * i);
         wb_out = 32'hA000_0000 + 32'(i);
         if (i < 16) expect_rec(npc, wb_out);
         step();
      end
      check("fill_level", 32'(level), 16);
      check("fill_ovf", 32'(overflow), 1);
      check("fill_drop", 32'(drop_cnt), 2);
      check("fill_head_pc", trace.out_pc, 32'h100);
      check("fill_head_wb", trace.out_wb, 32'hA000_0000);

      // 4. full with simultaneous pop
      trace.out_ready = 1'b1;
      npc    = 32'h200;
      wb_out = 32'hB000_0000;
      expect_rec(npc, wb_out);
      step();
      trace.out_ready = 1'b0;
      check("fullpop_level", 32'(level), 16);
      check("fullpop_drop", 32'(drop_cnt), 2);
      check("fullpop_head", trace.out_pc, 32'h104);

      // 5. clear versus drop
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check("clr_ovf", 32'(overflow), 0);
      check("clr_drop", 32'(drop_cnt), 0);
      clr_ovf = 1'b1;
      npc     = 32'h204;
      step();
      clr_ovf = 1'b0;
      check("clrdrop_ovf", 32'(overflow), 1);
      check("clrdrop_drop", 32'(drop_cnt), 1);
      check("clrdrop_level", 32'(level), 16);

      // 6a. en = 0: drain while NPC changes; nothing new may be queued
      en = 1'b0;
      trace.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i < 3) npc = 32'h300 + 32'(4 * i);
         step();
      end
      trace.out_ready = 1'b0;
      check("en0_level", 32'(level), 0);
      check("en0_valid", 32'(trace.out_valid), 0);
      check("en0_drop", 32'(drop_cnt), 1);
      check("en0_sb_empty", 32'(sb.size()), 0);

      // 6b. 40 records streamed across pointer wrap and timestamp wrap
      en = 1'b1;
      guard = 0;
      while (model_ts != 16'hFFE0 && guard < 70000) begin
         step();
         guard++;
      end
      check("ts_reach", 32'(model_ts), 32'hFFE0);
      trace.out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         npc    = 32'h1000 + 32'(4 * i);
         wb_out = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
         expect_rec(npc, wb_out);
         step();
      end
      repeat (2) step();
      trace.out_ready = 1'b0;
      check("wrap_level", 32'(level), 0);
      check("wrap_sb_empty", 32'(sb.size()), 0);

      // reset mid-operation flushes contents and disarms
      for (int i = 0; i < 3; i++) begin
         npc = 32'h2000 + 32'(4 * i);
         step();
      end
      check("pre_rst_level", 32'(level), 3);
      rn  = 1'b1;
      npc = 32'h3000;
      step();
      check("rst_level", 32'(level), 0);
      check("rst_valid", 32'(trace.out_valid), 0);
      check("rst_pc", trace.out_pc, 0);
      check("rst_drop", 32'(drop_cnt), 0);
      rn  = 1'b0;
      npc = 32'h3004;
      step();
      check("rearm_level", 32'(level), 0);
      npc    = 32'h3008;
      wb_out = 32'h1234_5678;
      expect_rec(npc, wb_out);
      step();
      check("post_rst_pc", trace.out_pc, 32'h3008);
      check("post_rst_ts", 32'(trace.out_ts), 1);
      trace.out_ready = 1'b1;
      step();
      trace.out_ready = 1'b0;
      check("final_sb_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
